// File: rtl/ahb_periph_port_arbiter.sv
// rtl/ahb_periph_port_arbiter.sv - round-robin sharing of the single-outstanding peripheral-port bridge
// Serialises whole A/D pairs from two requesters and steers each D response to its owner.
module ahb_periph_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                r0_a_valid,
  output logic                r0_a_ready,
  input  logic [2:0]          r0_a_opcode,
  input  logic [2:0]          r0_a_size,
  input  logic [SRC_W-1:0]    r0_a_source,
  input  logic [ADDR_W-1:0]   r0_a_address,
  input  logic [DATA_W/8-1:0] r0_a_mask,
  input  logic [DATA_W-1:0]   r0_a_data,
  output logic                r0_d_valid,
  input  logic                r0_d_ready,
  output logic [2:0]          r0_d_opcode,
  output logic [2:0]          r0_d_size,
  output logic [SRC_W-1:0]    r0_d_source,
  output logic [DATA_W-1:0]   r0_d_data,
  output logic                r0_d_denied,
  input  logic                r1_a_valid,
  output logic                r1_a_ready,
  input  logic [2:0]          r1_a_opcode,
  input  logic [2:0]          r1_a_size,
  input  logic [SRC_W-1:0]    r1_a_source,
  input  logic [ADDR_W-1:0]   r1_a_address,
  input  logic [DATA_W/8-1:0] r1_a_mask,
  input  logic [DATA_W-1:0]   r1_a_data,
  output logic                r1_d_valid,
  input  logic                r1_d_ready,
  output logic [2:0]          r1_d_opcode,
  output logic [2:0]          r1_d_size,
  output logic [SRC_W-1:0]    r1_d_source,
  output logic [DATA_W-1:0]   r1_d_data,
  output logic                r1_d_denied,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_opcode,
  output logic [2:0]          out_a_size,
  output logic [SRC_W-1:0]    out_a_source,
  output logic [ADDR_W-1:0]   out_a_address,
  output logic [DATA_W/8-1:0] out_a_mask,
  output logic [DATA_W-1:0]   out_a_data,
  input  logic                out_d_valid,
  output logic                out_d_ready,
  input  logic [2:0]          out_d_opcode,
  input  logic [2:0]          out_d_size,
  input  logic [SRC_W-1:0]    out_d_source,
  input  logic [DATA_W-1:0]   out_d_data,
  input  logic                out_d_denied,
  output logic                busy,
  output logic                grant_id,
  output logic                err_src
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_D} state_e;

  state_e                state_q;
  logic                  prio_q;
  logic                  grant_q;
  logic                  err_q;
  logic [2:0]            a_opcode_q, a_size_q;
  logic [SRC_W-1:0]      a_source_q;
  logic [ADDR_W-1:0]     a_address_q;
  logic [DATA_W/8-1:0]   a_mask_q;
  logic [DATA_W-1:0]     a_data_q;

  logic                  any_req;
  logic                  win;
  logic                  accept;
  logic                  owner_d_ready;
  logic                  d_hs;
  logic [2:0]            a_opcode_d, a_size_d;
  logic [SRC_W-1:0]      a_source_d;
  logic [ADDR_W-1:0]     a_address_d;
  logic [DATA_W/8-1:0]   a_mask_d;
  logic [DATA_W-1:0]     a_data_d;

  // A lone requester always wins; prio only breaks a tie.
  always_comb begin
    any_req     = r0_a_valid | r1_a_valid;
    win         = (r0_a_valid & r1_a_valid) ? prio_q : r1_a_valid;
    a_opcode_d  = win ? r1_a_opcode  : r0_a_opcode;
    a_size_d    = win ? r1_a_size    : r0_a_size;
    a_source_d  = win ? r1_a_source  : r0_a_source;
    a_address_d = win ? r1_a_address : r0_a_address;
    a_mask_d    = win ? r1_a_mask    : r0_a_mask;
    a_data_d    = win ? r1_a_data    : r0_a_data;
  end

  assign accept        = (state_q == IDLE) && any_req;
  assign r0_a_ready    = accept && !win;
  assign r1_a_ready    = accept && win;
  assign owner_d_ready = grant_q ? r1_d_ready : r0_d_ready;
  assign out_d_ready   = (state_q == WAIT_D) && owner_d_ready;
  assign r0_d_valid    = (state_q == WAIT_D) && !grant_q && out_d_valid;
  assign r1_d_valid    = (state_q == WAIT_D) && grant_q && out_d_valid;
  assign d_hs          = out_d_valid && out_d_ready;

  assign r0_d_opcode = out_d_opcode;
  assign r0_d_size   = out_d_size;
  assign r0_d_source = out_d_source;
  assign r0_d_data   = out_d_data;
  assign r0_d_denied = out_d_denied;
  assign r1_d_opcode = out_d_opcode;
  assign r1_d_size   = out_d_size;
  assign r1_d_source = out_d_source;
  assign r1_d_data   = out_d_data;
  assign r1_d_denied = out_d_denied;

  assign out_a_valid   = (state_q == ISSUE);
  assign out_a_opcode  = a_opcode_q;
  assign out_a_size    = a_size_q;
  assign out_a_source  = a_source_q;
  assign out_a_address = a_address_q;
  assign out_a_mask    = a_mask_q;
  assign out_a_data    = a_data_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;
  assign err_src       = err_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      grant_q     <= 1'b0;
      err_q       <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= ISSUE;
            grant_q     <= win;
            a_opcode_q  <= a_opcode_d;
            a_size_q    <= a_size_d;
            a_source_q  <= a_source_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
          end
        end
        ISSUE: begin
          if (out_a_ready) state_q <= WAIT_D;
        end
        WAIT_D: begin
          // Mismatched source is flagged but the response is still handed over.
          if (d_hs) begin
            state_q <= IDLE;
            prio_q  <= ~grant_q;
            if (out_d_source != a_source_q) err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_periph_port_arbiter.sv
// tb/tb_ahb_periph_port_arbiter.sv - directed and randomized checks of ahb_periph_port_arbiter
module tb_ahb_periph_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        r0_a_valid, r0_a_ready, r0_d_valid, r0_d_ready, r0_d_denied;
  logic [2:0]  r0_a_opcode, r0_a_size, r0_a_source, r0_d_opcode, r0_d_size, r0_d_source;
  logic [31:0] r0_a_address, r0_a_data, r0_d_data;
  logic [3:0]  r0_a_mask;
  logic        r1_a_valid, r1_a_ready, r1_d_valid, r1_d_ready, r1_d_denied;
  logic [2:0]  r1_a_opcode, r1_a_size, r1_a_source, r1_d_opcode, r1_d_size, r1_d_source;
  logic [31:0] r1_a_address, r1_a_data, r1_d_data;
  logic [3:0]  r1_a_mask;
  logic        out_a_valid, out_a_ready, out_d_valid, out_d_ready, out_d_denied;
  logic [2:0]  out_a_opcode, out_a_size, out_a_source, out_d_opcode, out_d_size, out_d_source;
  logic [31:0] out_a_address, out_a_data, out_d_data;
  logic [3:0]  out_a_mask;
  logic        busy, grant_id, err_src;

  ahb_periph_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
    .clock(clock), .reset(reset),
    .r0_a_valid(r0_a_valid), .r0_a_ready(r0_a_ready), .r0_a_opcode(r0_a_opcode),
    .r0_a_size(r0_a_size), .r0_a_source(r0_a_source), .r0_a_address(r0_a_address),
    .r0_a_mask(r0_a_mask), .r0_a_data(r0_a_data), .r0_d_valid(r0_d_valid),
    .r0_d_ready(r0_d_ready), .r0_d_opcode(r0_d_opcode), .r0_d_size(r0_d_size),
    .r0_d_source(r0_d_source), .r0_d_data(r0_d_data), .r0_d_denied(r0_d_denied),
    .r1_a_valid(r1_a_valid), .r1_a_ready(r1_a_ready), .r1_a_opcode(r1_a_opcode),
    .r1_a_size(r1_a_size), .r1_a_source(r1_a_source), .r1_a_address(r1_a_address),
    .r1_a_mask(r1_a_mask), .r1_a_data(r1_a_data), .r1_d_valid(r1_d_valid),
    .r1_d_ready(r1_d_ready), .r1_d_opcode(r1_d_opcode), .r1_d_size(r1_d_size),
    .r1_d_source(r1_d_source), .r1_d_data(r1_d_data), .r1_d_denied(r1_d_denied),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address),
    .out_a_mask(out_a_mask), .out_a_data(out_a_data), .out_d_valid(out_d_valid),
    .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode), .out_d_size(out_d_size),
    .out_d_source(out_d_source), .out_d_data(out_d_data), .out_d_denied(out_d_denied),
    .busy(busy), .grant_id(grant_id), .err_src(err_src)
  );

  int checks = 0;
  int errors = 0;
  int d0_hs_cnt = 0;

  // Reference model: pending requests, transaction phase (0 idle, 1 A out, 2 awaiting D)
  logic        pend [2];
  logic [2:0]  q_op [2], q_size [2], q_src [2];
  logic [31:0] q_addr [2], q_data [2];
  logic [3:0]  q_mask [2];
  logic        m_prio, m_err, m_grant;
  int          m_phase;
  logic [2:0]  m_op, m_size, m_src;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_mask;
  logic        grants [$];

  always @(negedge clock) if (r0_d_valid && r0_d_ready) d0_hs_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic zero_inputs;
    r0_a_valid = 0; r0_a_opcode = 0; r0_a_size = 0; r0_a_source = 0;
    r0_a_address = 0; r0_a_mask = 0; r0_a_data = 0; r0_d_ready = 0;
    r1_a_valid = 0; r1_a_opcode = 0; r1_a_size = 0; r1_a_source = 0;
    r1_a_address = 0; r1_a_mask = 0; r1_a_data = 0; r1_d_ready = 0;
    out_a_ready = 0; out_d_valid = 0; out_d_opcode = 0; out_d_size = 0;
    out_d_source = 0; out_d_data = 0; out_d_denied = 0;
  endtask

  task automatic model_reset;
    pend[0] = 0; pend[1] = 0;
    m_prio = 0; m_err = 0; m_grant = 0; m_phase = 0;
    grants.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_a_valid"}, out_a_valid, 0);
    chk({tag, "_out_d_ready"}, out_d_ready, 0);
    chk({tag, "_r0_a_ready"}, r0_a_ready, 0);
    chk({tag, "_r1_a_ready"}, r1_a_ready, 0);
    chk({tag, "_r0_d_valid"}, r0_d_valid, 0);
    chk({tag, "_r1_d_valid"}, r1_d_valid, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_err_src"}, err_src, 0);
    chk({tag, "_out_a_fields"}, {out_a_opcode, out_a_size, out_a_source, out_a_mask}, 0);
    chk({tag, "_out_a_address"}, out_a_address, 0);
    chk({tag, "_out_a_data"}, out_a_data, 0);
  endtask

  task automatic do_reset;
    zero_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
    model_reset();
  endtask

  task automatic run(input string tag, input int ntxn, input bit always_req, input bit fast);
    int   done;
    int   cyc;
    bit   dh;
    logic w;
    done = 0;
    cyc  = 0;
    while (done < ntxn && cyc < 3000) begin
      cyc++;
      dh = 0;
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && (always_req || $urandom_range(0, 2) == 0)) begin
          pend[n]   = 1'b1;
          q_op[n]   = 3'($urandom_range(0, 7));
          q_size[n] = 3'($urandom_range(0, 2));
          q_src[n]  = 3'($urandom_range(0, 7));
          q_addr[n] = $urandom;
          q_mask[n] = 4'($urandom_range(0, 15));
          q_data[n] = $urandom;
        end
      end
      r0_a_valid = pend[0]; r0_a_opcode = q_op[0]; r0_a_size = q_size[0]; r0_a_source = q_src[0];
      r0_a_address = q_addr[0]; r0_a_mask = q_mask[0]; r0_a_data = q_data[0];
      r1_a_valid = pend[1]; r1_a_opcode = q_op[1]; r1_a_size = q_size[1]; r1_a_source = q_src[1];
      r1_a_address = q_addr[1]; r1_a_mask = q_mask[1]; r1_a_data = q_data[1];
      out_a_ready = fast || ($urandom_range(0, 1) == 1);
      if (m_phase == 2 && !out_d_valid && (fast || $urandom_range(0, 1) == 1)) begin
        out_d_valid  = 1;
        out_d_opcode = 3'($urandom_range(0, 7));
        out_d_size   = m_size;
        out_d_data   = $urandom;
        out_d_denied = ($urandom_range(0, 3) == 0);
        out_d_source = ($urandom_range(0, 5) == 0) ? m_src + 3'd1 : m_src;
      end
      r0_d_ready = fast || ($urandom_range(0, 1) == 1);
      r1_d_ready = fast || ($urandom_range(0, 1) == 1);
      #1;
      chk({tag, "_err_src"}, err_src, m_err);
      chk({tag, "_busy"}, busy, m_phase != 0);
      if (m_phase == 0) begin
        w = (pend[0] && pend[1]) ? m_prio : pend[1];
        chk({tag, "_r0_a_ready"}, r0_a_ready, (pend[0] || pend[1]) && !w);
        chk({tag, "_r1_a_ready"}, r1_a_ready, (pend[0] || pend[1]) && w);
        chk({tag, "_idle_out_a_valid"}, out_a_valid, 0);
        chk({tag, "_idle_out_d_ready"}, out_d_ready, 0);
        if (pend[0] || pend[1]) begin
          m_grant = w;
          m_op = q_op[w]; m_size = q_size[w]; m_src = q_src[w];
          m_addr = q_addr[w]; m_mask = q_mask[w]; m_data = q_data[w];
          pend[w] = 0;
          grants.push_back(w);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        chk({tag, "_grant_id"}, grant_id, m_grant);
        chk({tag, "_out_a_valid"}, out_a_valid, 1);
        chk({tag, "_out_a_addr"}, out_a_address, m_addr);
        chk({tag, "_out_a_data"}, out_a_data, m_data);
        chk({tag, "_out_a_ctl"}, {out_a_opcode, out_a_size, out_a_source, out_a_mask},
            {m_op, m_size, m_src, m_mask});
        chk({tag, "_issue_a_ready"}, {r0_a_ready, r1_a_ready}, 0);
        chk({tag, "_issue_d_ready"}, out_d_ready, 0);
        if (out_a_ready) m_phase = 2;
      end else begin
        chk({tag, "_wait_grant_id"}, grant_id, m_grant);
        chk({tag, "_wait_a_ready"}, {r0_a_ready, r1_a_ready}, 0);
        chk({tag, "_r0_d_valid"}, r0_d_valid, out_d_valid && !m_grant);
        chk({tag, "_r1_d_valid"}, r1_d_valid, out_d_valid && m_grant);
        chk({tag, "_out_d_ready"}, out_d_ready, m_grant ? r1_d_ready : r0_d_ready);
        if (out_d_valid) begin
          chk({tag, "_d_data"}, m_grant ? r1_d_data : r0_d_data, out_d_data);
          chk({tag, "_d_src"}, m_grant ? r1_d_source : r0_d_source, out_d_source);
          chk({tag, "_d_denied"}, m_grant ? r1_d_denied : r0_d_denied, out_d_denied);
          dh = m_grant ? r1_d_ready : r0_d_ready;
        end
        if (dh) begin
          if (out_d_source != m_src) m_err = 1;
          m_prio  = !m_grant;
          m_phase = 0;
          done++;
        end
      end
      tick();
      if (dh) out_d_valid = 0;
    end
    chk({tag, "_completed"}, done, ntxn);
  endtask

  task automatic one_txn_r0(input logic [31:0] addr, input logic [2:0] src, input logic [2:0] dsrc);
    r0_a_valid = 1; r0_a_address = addr; r0_a_source = src; r0_a_opcode = 3'd4; r0_a_size = 3'd2;
    #1;
    chk("txn_r0_a_ready", r0_a_ready, 1);
    tick();
    r0_a_valid = 0; out_a_ready = 1;
    tick();
    out_a_ready = 0; out_d_valid = 1; out_d_source = dsrc; out_d_data = 32'h0BAD_F00D; r0_d_ready = 1;
    #1;
    chk("txn_r0_d_valid", r0_d_valid, 1);
    tick();
    out_d_valid = 0; r0_d_ready = 0;
  endtask

  initial begin
    int d0_before;
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0_before;
    zero_inputs();
    reset = 0;
    tick();
    chk_reset_state("reset");
    reset = 1;
    model_reset();

    // Single read, minimum latency
    r0_a_valid = 1; r0_a_address = 32'h2000_0004; r0_a_source = 3'd1; r0_a_opcode = 3'd4;
    r0_a_size = 3'd2; r0_a_mask = 4'hF;
    #1;
    chk("rd_c0_r0_a_ready", r0_a_ready, 1);
    chk("rd_c0_r1_a_ready", r1_a_ready, 0);
    chk("rd_c0_out_a_valid", out_a_valid, 0);
    tick();
    r0_a_valid = 0; out_a_ready = 1;
    #1;
    chk("rd_c1_out_a_valid", out_a_valid, 1);
    chk("rd_c1_out_a_address", out_a_address, 32'h2000_0004);
    chk("rd_c1_out_a_source", out_a_source, 1);
    chk("rd_c1_r0_a_ready", r0_a_ready, 0);
    chk("rd_c1_r1_d_valid", r1_d_valid, 0);
    tick();
    out_a_ready = 0; out_d_valid = 1; out_d_data = 32'hDEAD_BEEF; out_d_source = 3'd1;
    out_d_opcode = 3'd1; out_d_size = 3'd2; r0_d_ready = 1;
    #1;
    chk("rd_c2_r0_d_valid", r0_d_valid, 1);
    chk("rd_c2_r0_d_data", r0_d_data, 32'hDEAD_BEEF);
    chk("rd_c2_r1_d_valid", r1_d_valid, 0);
    chk("rd_c2_out_d_ready", out_d_ready, 1);
    tick();
    out_d_valid = 0; r0_d_ready = 0;
    #1;
    chk("rd_c3_busy", busy, 0);
    chk("rd_c3_err_src", err_src, 0);

    // Stalls on A and on the requester's D ready
    d0_before = d0_hs_cnt;
    r0_a_valid = 1; r0_a_address = 32'h1000_0010; r0_a_source = 3'd3; r0_a_data = 32'h1234_5678;
    r0_a_opcode = 3'd0;
    tick();
    r0_a_valid = 0; r0_a_address = 32'hFFFF_FFFF; r0_a_data = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_a_valid", out_a_valid, 1);
      chk("stall_a_address", out_a_address, 32'h1000_0010);
      chk("stall_a_data", out_a_data, 32'h1234_5678);
      tick();
    end
    out_a_ready = 1;
    tick();
    out_a_ready = 0; out_d_valid = 1; out_d_source = 3'd3; out_d_data = 32'hA5A5_5A5A; r0_d_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_d_r0_d_valid", r0_d_valid, 1);
      chk("stall_d_out_d_ready", out_d_ready, 0);
      tick();
    end
    r0_d_ready = 1;
    #1;
    chk("stall_d_release", out_d_ready, 1);
    tick();
    out_d_valid = 0; r0_d_ready = 0;
    #1;
    chk("stall_one_d", d0_hs_cnt - d0_before, 1);
    chk("stall_idle", busy, 0);

    // Source mismatch is sticky through a later clean transaction
    one_txn_r0(32'h3000_0000, 3'd1, 3'd2);
    #1;
    chk("err_set", err_src, 1);
    one_txn_r0(32'h3000_0004, 3'd5, 3'd5);
    #1;
    chk("err_sticky", err_src, 1);

    // Reset in WAIT_D with prio currently pointing at r1
    r1_a_valid = 1; r1_a_address = 32'h4000_0008; r1_a_source = 3'd6;
    tick();
    r1_a_valid = 0; out_a_ready = 1;
    tick();
    out_a_ready = 0; out_d_valid = 1; r1_d_ready = 0; out_d_source = 3'd6;
    #1;
    chk("rst_pre_r1_d_valid", r1_d_valid, 1);
    chk("rst_pre_busy", busy, 1);
    reset = 0; r1_d_ready = 1;
    tick();
    chk("rst_wait_r1_d_valid", r1_d_valid, 0);
    chk("rst_wait_out_d_ready", out_d_ready, 0);
    out_d_valid = 0; r1_d_ready = 0;
    chk_reset_state("rst_wait");
    reset = 1;
    r0_a_valid = 1; r1_a_valid = 1; r0_a_address = 32'h5; r1_a_address = 32'h4000_0010;
    #1;
    chk("rst_prio_r0_wins", {r0_a_ready, r1_a_ready}, 2'b10);
    r0_a_valid = 0;
    #1;
    chk("rst_r1_alone_ready", r1_a_ready, 1);
    tick();
    r1_a_valid = 0; out_a_ready = 1;
    #1;
    chk("rst_r1_grant", grant_id, 1);
    chk("rst_r1_addr", out_a_address, 32'h4000_0010);
    tick();
    out_a_ready = 0; out_d_valid = 1; out_d_source = 3'd0; r1_d_ready = 1;
    #1;
    chk("rst_r1_d_valid", {r0_d_valid, r1_d_valid}, 2'b01);
    tick();
    out_d_valid = 0; r1_d_ready = 0;
    #1;
    chk("rst_r1_done", busy, 0);

    // Both requesting from reset: strict alternation
    do_reset();
    run("rr", 8, 1'b1, 1'b1);
    for (int i = 0; i < grants.size(); i++) chk("rr_order", grants[i], i % 2);

    // Randomized traffic and back-pressure against the model
    do_reset();
    run("rand", 60, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
